// File: rtl/paddle_ctrl.sv
// Two-paddle vertical motion controller: synchronizes the key levels and steps
// each paddle once per motion tick with slow/fast acceleration and clamping.
module paddle_ctrl #(
  parameter int TICK_DIV   = 1666667,
  parameter int SCREEN_H   = 480,
  parameter int PADDLE_H   = 80,
  parameter int STEP_SLOW  = 4,
  parameter int STEP_FAST  = 8,
  parameter int HOLD_TICKS = 15
) (
  input  logic       paddle_clk,
  input  logic       paddle_rst,
  input  logic [3:0] paddle_keys,
  output logic [9:0] paddle_left_y,
  output logic [9:0] paddle_right_y,
  output logic       paddle_tick
);

  localparam int             CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX  = CW'(TICK_DIV - 1);
  localparam int             HW       = $clog2(HOLD_TICKS + 2);
  localparam logic [HW-1:0]  HOLD_MAX = HW'(HOLD_TICKS);
  localparam logic [10:0]    Y_MAX    = 11'(SCREEN_H - PADDLE_H);
  localparam logic [9:0]     Y_RST    = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [10:0]    STEP_S   = 11'(STEP_SLOW);
  localparam logic [10:0]    STEP_F   = 11'(STEP_FAST);

  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

  logic [3:0]    key_meta_q, key_meta_d;
  logic [3:0]    key_sync_q, key_sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  state_t        state_q [2];
  state_t        state_d [2];
  logic [HW-1:0] hold_q  [2];
  logic [HW-1:0] hold_d  [2];
  logic          dir_q   [2];
  logic          dir_d   [2];
  logic [9:0]    y_q     [2];
  logic [9:0]    y_d     [2];
  logic          up_req  [2];
  logic          dn_req  [2];

  // Clamp by comparing against the remaining headroom, so no sum can wrap.
  function automatic logic [9:0] step_y(input logic [9:0] y, input logic down,
                                        input logic [10:0] step);
    logic [10:0] y_ext;
    logic [10:0] res;
    y_ext = {1'b0, y};
    if (down) res = (step >= Y_MAX - y_ext) ? Y_MAX : y_ext + step;
    else      res = (step >= y_ext) ? 11'd0 : y_ext - step;
    return 10'(res);
  endfunction

  always_comb begin
    key_meta_d = paddle_keys;
    key_sync_d = key_meta_q;
    cnt_d      = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    tick_d     = (cnt_d == CNT_MAX);
    up_req[0]  = key_sync_q[2];
    dn_req[0]  = key_sync_q[3];
    up_req[1]  = key_sync_q[0];
    dn_req[1]  = key_sync_q[1];
  end

  // dir = 1 means moving down (increasing Y).
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      state_d[p] = state_q[p];
      hold_d[p]  = hold_q[p];
      dir_d[p]   = dir_q[p];
      y_d[p]     = y_q[p];
      if (tick_q) begin
        if (up_req[p] == dn_req[p]) begin
          state_d[p] = IDLE;
          hold_d[p]  = '0;
        end else if (state_q[p] == IDLE || dn_req[p] != dir_q[p]) begin
          state_d[p] = SLOW;
          hold_d[p]  = HW'(1);
          dir_d[p]   = dn_req[p];
          y_d[p]     = step_y(y_q[p], dn_req[p], STEP_S);
        end else if (state_q[p] == SLOW) begin
          y_d[p] = step_y(y_q[p], dir_q[p], STEP_S);
          if (hold_q[p] + HW'(1) >= HOLD_MAX) begin
            hold_d[p]  = HOLD_MAX;
            state_d[p] = FAST;
          end else begin
            hold_d[p] = hold_q[p] + HW'(1);
          end
        end else begin
          y_d[p] = step_y(y_q[p], dir_q[p], STEP_F);
        end
      end
    end
  end

  always_ff @(posedge paddle_clk) begin
    if (paddle_rst) begin
      key_meta_q <= '0;
      key_sync_q <= '0;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= IDLE;
        hold_q[p]  <= '0;
        dir_q[p]   <= 1'b0;
        y_q[p]     <= Y_RST;
      end
    end else begin
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= state_d[p];
        hold_q[p]  <= hold_d[p];
        dir_q[p]   <= dir_d[p];
        y_q[p]     <= y_d[p];
      end
    end
  end

  assign paddle_left_y  = y_q[0];
  assign paddle_right_y = y_q[1];
  assign paddle_tick    = tick_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Randomized scoreboard bench for paddle_ctrl with a behavioural paddle model.
module tb_paddle_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int HOLD_TICKS = 3;
  localparam int STEP_SLOW  = 4;
  localparam int STEP_FAST  = 8;
  localparam int Y_MAX      = 400;
  localparam int Y_RST      = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] keys = 4'b0;
  logic [9:0] left_y, right_y;
  logic       tick;

  always #5 clk = ~clk;

  paddle_ctrl #(
    .TICK_DIV(TICK_DIV), .SCREEN_H(480), .PADDLE_H(80),
    .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .paddle_clk(clk), .paddle_rst(rst), .paddle_keys(keys),
    .paddle_left_y(left_y), .paddle_right_y(right_y), .paddle_tick(tick)
  );

  typedef struct {int left; int right;} pos_t;
  pos_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Model state: mode 0 idle, 1 slow, 2 fast; dir is -1 up, +1 down.
  int m_y[2], m_mode[2], m_hold[2], m_dir[2];
  int m_cnt;
  bit m_tick_exp = 1'b0;
  bit m_flush    = 1'b0;
  bit mon_en     = 1'b0;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  function automatic int clamp_y(input int v);
    if (v < 0) return 0;
    if (v > Y_MAX) return Y_MAX;
    return v;
  endfunction

  task automatic model_paddle(input int p, input bit up, input bit dn);
    int req;
    req = (up && !dn) ? -1 : ((dn && !up) ? 1 : 0);
    if (req == 0) begin
      m_mode[p] = 0;
      m_hold[p] = 0;
    end else if (m_mode[p] == 0 || req != m_dir[p]) begin
      m_mode[p] = 1;
      m_hold[p] = 1;
      m_dir[p]  = req;
      m_y[p]    = clamp_y(m_y[p] + req * STEP_SLOW);
    end else if (m_mode[p] == 1) begin
      m_y[p] = clamp_y(m_y[p] + req * STEP_SLOW);
      m_hold[p]++;
      if (m_hold[p] >= HOLD_TICKS) m_mode[p] = 2;
    end else begin
      m_y[p] = clamp_y(m_y[p] + req * STEP_FAST);
    end
  endtask

  // Reference model: keys reach the logic two edges late; a tick edge ends
  // every TICK_DIV-th cycle counted from reset.
  initial begin
    logic [3:0] h1, h2, k;
    h1 = '0;
    h2 = '0;
    m_cnt = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        h1 = '0;
        h2 = '0;
        m_cnt = 0;
        m_tick_exp = 1'b0;
        for (int p = 0; p < 2; p++) begin
          m_y[p] = Y_RST; m_mode[p] = 0; m_hold[p] = 0; m_dir[p] = 0;
        end
        exp_q.delete();
        m_flush = 1'b1;
        mon_en  = 1'b1;
      end else begin
        k  = h2;
        h2 = h1;
        h1 = keys;
        if (m_cnt == TICK_DIV - 1) begin
          model_paddle(0, k[2], k[3]);
          model_paddle(1, k[0], k[1]);
          exp_q.push_back('{m_y[0], m_y[1]});
        end
        m_cnt = (m_cnt + 1) % TICK_DIV;
        m_tick_exp = (m_cnt == TICK_DIV - 1);
      end
    end
  end

  // Monitor: after each DUT tick pop the expected positions; otherwise the
  // positions must hold their last value.
  initial begin
    bit   pending;
    pos_t last, e;
    pending = 1'b0;
    last = '{Y_RST, Y_RST};
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (m_flush) begin
          pending = 1'b0;
          last = '{Y_RST, Y_RST};
          m_flush = 1'b0;
        end
        check_output("tick", int'(tick), int'(m_tick_exp));
        if (pending) begin
          check_output("expect_available", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("left_y", int'(left_y), e.left);
            check_output("right_y", int'(right_y), e.right);
            last = e;
          end
          pending = 1'b0;
        end else begin
          check_output("left_y_hold", int'(left_y), last.left);
          check_output("right_y_hold", int'(right_y), last.right);
        end
        if (tick) pending = 1'b1;
      end
    end
  end

  task automatic apply_stimulus(input logic [3:0] k, input int cycles);
    keys = k;
    repeat (cycles) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int waited;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    apply_stimulus(4'b0000, 20);
    apply_stimulus(4'b0100, 5 * TICK_DIV);
    apply_stimulus(4'b0100, 60 * TICK_DIV);
    apply_stimulus(4'b1000, 4 * TICK_DIV);
    apply_stimulus(4'b0000, 8);
    apply_stimulus(4'b0010, 60 * TICK_DIV);
    apply_stimulus(4'b0011, 5 * TICK_DIV);
    apply_stimulus(4'b0000, 9);
    apply_stimulus(4'b0100, 1);
    apply_stimulus(4'b0000, 10);
    apply_stimulus(4'b0100, 3);
    apply_stimulus(4'b0000, 10);

    // Drive both paddles into FAST, then reset on a tick cycle.
    apply_stimulus(4'b1001, 6 * TICK_DIV);
    waited = 0;
    while (!tick && waited < 2 * TICK_DIV + 2) begin
      @(posedge clk);
      #2;
      waited++;
    end
    check_output("tick_seen_before_reset", int'(tick), 1);
    rst = 1'b1;
    apply_stimulus(4'b1001, 1);
    rst = 1'b0;
    apply_stimulus(4'b1001, 12);

    repeat (300) begin
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        apply_stimulus(keys, $urandom_range(1, 2));
        rst = 1'b0;
      end
      apply_stimulus(4'($urandom_range(0, 15)), $urandom_range(1, 12));
    end

    apply_stimulus(4'b0000, 8);
    check_output("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
